// File: rtl/urv_dm_ahb_bridge.sv
// urv_dm_ahb_bridge: CPU data-memory port to AHB-Lite master.
// One single transfer at a time; wait states and ERROR responses handled.
module urv_dm_ahb_bridge #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic        dm_ready_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_err_o,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]  state;
    logic        req;
    logic        sel_ok;
    logic [2:0]  dec_size;
    logic [1:0]  dec_lo;
    logic        accept;
    logic        reject;
    logic        finish;
    logic [31:0] haddr_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;
    logic [31:0] hwdata_q;
    logic [31:0] data_l_q;
    logic        load_done_q;
    logic        store_done_q;
    logic        err_q;

    assign req    = dm_store_i | dm_load_i;
    assign accept = (state == S_IDLE) & req & sel_ok;
    assign reject = (state == S_IDLE) & req & ~sel_ok;
    assign finish = (state == S_DATA) & HREADY;

    // Decode the lane-select pattern into transfer size and low address bits
    always_comb begin
        sel_ok   = 1'b1;
        dec_size = 3'd0;
        dec_lo   = dm_addr_i[1:0];
        case (dm_data_select_i)
            4'b1111: begin dec_size = 3'd2; dec_lo = 2'b00; end
            4'b0011: begin dec_size = 3'd1; dec_lo = 2'b00; end
            4'b1100: begin dec_size = 3'd1; dec_lo = 2'b10; end
            4'b0001: dec_lo = 2'b00;
            4'b0010: dec_lo = 2'b01;
            4'b0100: dec_lo = 2'b10;
            4'b1000: dec_lo = 2'b11;
            default: sel_ok = 1'b0;
        endcase
    end

    // Transfer sequencing: IDLE -> ADDR -> DATA -> IDLE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state <= S_ADDR;
                S_ADDR:  if (HREADY) state <= S_DATA;
                S_DATA:  if (HREADY) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Latch address/control of an accepted request; store data kept until next store
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            haddr_q  <= 32'd0;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'd0;
            hwdata_q <= 32'd0;
        end else if (accept) begin
            haddr_q  <= {dm_addr_i[31:2], dec_lo};
            hwrite_q <= dm_store_i;
            hsize_q  <= dec_size;
            if (dm_store_i) hwdata_q <= dm_data_s_i;
        end
    end

    // Capture load data at the completing data phase; errors return zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_l_q <= 32'd0;
        end else if (finish && !hwrite_q) begin
            data_l_q <= HRESP ? 32'd0 : HRDATA;
        end
    end

    // One-cycle done/error pulses for completed or rejected requests
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            load_done_q  <= (finish & ~hwrite_q) | (reject & ~dm_store_i);
            store_done_q <= (finish & hwrite_q) | (reject & dm_store_i);
            err_q        <= (finish & HRESP) | reject;
        end
    end

    assign dm_ready_o      = (state == S_IDLE);
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign dm_err_o        = err_q;
    assign dm_data_l_o     = data_l_q;

    assign HTRANS    = (state == S_ADDR) ? 2'b10 : 2'b00;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_VAL;

endmodule

// File: tb/tb_urv_dm_ahb_bridge.sv
// tb_urv_dm_ahb_bridge: directed checks of the data-port AHB bridge.
// The bench plays the AHB slave by driving HREADY/HRESP/HRDATA per cycle.
module tb_urv_dm_ahb_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_data_s_i = '0;
    logic [3:0]  dm_data_select_i = '0;
    logic        dm_store_i = 1'b0;
    logic        dm_load_i = 1'b0;
    logic        dm_ready_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic [31:0] dm_data_l_o;
    logic        dm_err_o;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    int checks = 0;
    int failures = 0;

    urv_dm_ahb_bridge dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .dm_addr_i(dm_addr_i),
        .dm_data_s_i(dm_data_s_i),
        .dm_data_select_i(dm_data_select_i),
        .dm_store_i(dm_store_i),
        .dm_load_i(dm_load_i),
        .dm_ready_o(dm_ready_o),
        .dm_load_done_o(dm_load_done_o),
        .dm_store_done_o(dm_store_done_o),
        .dm_data_l_o(dm_data_l_o),
        .dm_err_o(dm_err_o),
        .HADDR(HADDR),
        .HTRANS(HTRANS),
        .HWRITE(HWRITE),
        .HSIZE(HSIZE),
        .HBURST(HBURST),
        .HMASTLOCK(HMASTLOCK),
        .HPROT(HPROT),
        .HWDATA(HWDATA),
        .HRDATA(HRDATA),
        .HREADY(HREADY),
        .HRESP(HRESP)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Present a request for one edge; returns in cycle 1 after acceptance
    task automatic issue(input logic st, input logic ld,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        dm_store_i       = st;
        dm_load_i        = ld;
        dm_addr_i        = a;
        dm_data_s_i      = d;
        dm_data_select_i = s;
        step();
        dm_store_i = 1'b0;
        dm_load_i  = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst_i = 1'b0;
        step();

        // reset state
        chk("rst_ready", 32'(dm_ready_o), 32'd1);
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_hsize", 32'(HSIZE), 32'd0);
        chk("rst_data_l", dm_data_l_o, 32'd0);
        chk("rst_dones", 32'({dm_load_done_o, dm_store_done_o, dm_err_o}), 32'd0);
        chk("const_hburst", 32'(HBURST), 32'd0);
        chk("const_hlock", 32'(HMASTLOCK), 32'd0);
        chk("const_hprot", 32'(HPROT), 32'h3);

        // word store then word load, zero-wait
        issue(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'b1111);
        chk("ws_htrans1", 32'(HTRANS), 32'd2);
        chk("ws_haddr", HADDR, 32'h100);
        chk("ws_hsize", 32'(HSIZE), 32'd2);
        chk("ws_hwrite", 32'(HWRITE), 32'd1);
        chk("ws_ready1", 32'(dm_ready_o), 32'd0);
        step();
        chk("ws_htrans2", 32'(HTRANS), 32'd0);
        chk("ws_hwdata", HWDATA, 32'hDEADBEEF);
        chk("ws_ready2", 32'(dm_ready_o), 32'd0);
        chk("ws_done2", 32'(dm_store_done_o), 32'd0);
        step();
        chk("ws_done3", 32'(dm_store_done_o), 32'd1);
        chk("ws_err3", 32'(dm_err_o), 32'd0);
        chk("ws_ready3", 32'(dm_ready_o), 32'd1);
        issue(1'b0, 1'b1, 32'h100, 32'd0, 4'b1111);
        chk("wl_sdone_clr", 32'(dm_store_done_o), 32'd0);
        chk("wl_htrans1", 32'(HTRANS), 32'd2);
        chk("wl_hwrite", 32'(HWRITE), 32'd0);
        step();
        HRDATA = 32'hDEADBEEF;
        step();
        chk("wl_done3", 32'(dm_load_done_o), 32'd1);
        chk("wl_data", dm_data_l_o, 32'hDEADBEEF);

        // byte and halfword lane decoding
        issue(1'b1, 1'b0, 32'h203, 32'h00AB0000, 4'b0100);
        chk("bs_haddr", HADDR, 32'h202);
        chk("bs_hsize", 32'(HSIZE), 32'd0);
        step();
        chk("bs_hwdata", HWDATA, 32'h00AB0000);
        step();
        chk("bs_done", 32'(dm_store_done_o), 32'd1);
        issue(1'b0, 1'b1, 32'h200, 32'd0, 4'b1100);
        chk("hl_haddr", HADDR, 32'h202);
        chk("hl_hsize", 32'(HSIZE), 32'd1);
        chk("hl_hwdata_hold", HWDATA, 32'h00AB0000);
        HRDATA = 32'h12340000;
        step();
        step();
        chk("hl_done", 32'(dm_load_done_o), 32'd1);
        chk("hl_data", dm_data_l_o, 32'h12340000);
        issue(1'b1, 1'b0, 32'h200, 32'h5A000000, 4'b1000);
        chk("b3_haddr", HADDR, 32'h203);
        chk("b3_hsize", 32'(HSIZE), 32'd0);
        step();
        step();
        chk("b3_done", 32'(dm_store_done_o), 32'd1);

        // 2 address-phase and 3 data-phase wait states on a load
        issue(1'b0, 1'b1, 32'h300, 32'd0, 4'b1111);
        for (int c = 1; c <= 7; c++) begin
            chk("wt_ready", 32'(dm_ready_o), 32'd0);
            chk("wt_htrans", 32'(HTRANS), (c <= 3) ? 32'd2 : 32'd0);
            chk("wt_haddr", HADDR, 32'h300);
            chk("wt_hsize", 32'(HSIZE), 32'd2);
            chk("wt_done", 32'(dm_load_done_o), 32'd0);
            HREADY = (c == 3) || (c == 7);
            HRDATA = (c == 7) ? 32'hCAFEF00D : 32'h0BAD0BAD;
            step();
        end
        chk("wt_done8", 32'(dm_load_done_o), 32'd1);
        chk("wt_data8", dm_data_l_o, 32'hCAFEF00D);
        chk("wt_ready8", 32'(dm_ready_o), 32'd1);
        HREADY = 1'b1;

        // two-cycle ERROR on a store, then a clean load
        issue(1'b1, 1'b0, 32'h400, 32'h55, 4'b1111);
        step();
        HREADY = 1'b0;
        HRESP  = 1'b1;
        step();
        chk("es_done3", 32'(dm_store_done_o), 32'd0);
        chk("es_ready3", 32'(dm_ready_o), 32'd0);
        chk("es_htrans3", 32'(HTRANS), 32'd0);
        HREADY = 1'b1;
        step();
        chk("es_done4", 32'(dm_store_done_o), 32'd1);
        chk("es_err4", 32'(dm_err_o), 32'd1);
        HRESP = 1'b0;
        issue(1'b0, 1'b1, 32'h100, 32'd0, 4'b1111);
        chk("es_err_clr", 32'(dm_err_o), 32'd0);
        step();
        HRDATA = 32'h11223344;
        step();
        chk("el_done", 32'(dm_load_done_o), 32'd1);
        chk("el_err", 32'(dm_err_o), 32'd0);
        chk("el_data", dm_data_l_o, 32'h11223344);

        // ERROR on a load returns zero
        issue(1'b0, 1'b1, 32'h104, 32'd0, 4'b1111);
        step();
        HREADY = 1'b0;
        HRESP  = 1'b1;
        step();
        HREADY = 1'b1;
        step();
        chk("le_done", 32'(dm_load_done_o), 32'd1);
        chk("le_err", 32'(dm_err_o), 32'd1);
        chk("le_data", dm_data_l_o, 32'd0);
        HRESP = 1'b0;
        issue(1'b0, 1'b1, 32'h108, 32'd0, 4'b1111);
        step();
        HRDATA = 32'hA5A55A5A;
        step();
        chk("pl_data", dm_data_l_o, 32'hA5A55A5A);

        // illegal select on a load and on a store
        issue(1'b0, 1'b1, 32'h10, 32'd0, 4'b0101);
        chk("il_htrans1", 32'(HTRANS), 32'd0);
        chk("il_ldone1", 32'(dm_load_done_o), 32'd1);
        chk("il_sdone1", 32'(dm_store_done_o), 32'd0);
        chk("il_err1", 32'(dm_err_o), 32'd1);
        chk("il_ready1", 32'(dm_ready_o), 32'd1);
        chk("il_data1", dm_data_l_o, 32'hA5A55A5A);
        step();
        chk("il_ldone2", 32'(dm_load_done_o), 32'd0);
        chk("il_err2", 32'(dm_err_o), 32'd0);
        chk("il_htrans2", 32'(HTRANS), 32'd0);
        issue(1'b1, 1'b0, 32'h20, 32'd0, 4'b0000);
        chk("is_sdone1", 32'(dm_store_done_o), 32'd1);
        chk("is_err1", 32'(dm_err_o), 32'd1);
        chk("is_htrans1", 32'(HTRANS), 32'd0);

        // reset during a data-phase wait
        issue(1'b0, 1'b1, 32'h500, 32'd0, 4'b1111);
        step();
        HREADY = 1'b0;
        #1 rst_i = 1'b1;
        #1;
        chk("rs_ready", 32'(dm_ready_o), 32'd1);
        chk("rs_htrans", 32'(HTRANS), 32'd0);
        chk("rs_haddr", HADDR, 32'd0);
        step();
        rst_i  = 1'b0;
        HREADY = 1'b1;
        step();
        chk("rs_nodone", 32'({dm_load_done_o, dm_store_done_o, dm_err_o}), 32'd0);
        chk("rs_data", dm_data_l_o, 32'd0);
        issue(1'b1, 1'b0, 32'h600, 32'h77, 4'b1111);
        chk("rs_htrans1", 32'(HTRANS), 32'd2);
        chk("rs_haddr1", HADDR, 32'h600);
        step();
        chk("rs_hwdata", HWDATA, 32'h77);
        step();
        chk("rs_done3", 32'(dm_store_done_o), 32'd1);
        chk("rs_err3", 32'(dm_err_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/urv_dm_ahb_bridge.md
# urv_dm_ahb_bridge

Responder for the urv_cpu data-memory port (dm_*) that turns each load or store request into a single AHB-Lite master transfer. It sits between the CPU data port and the AHB-Lite fabric, so data accesses reach the same AHB slaves as instruction fetch. It handles one transfer at a time, with no bursts and no pipelining of consecutive requests. Slave wait states and two-cycle ERROR responses are fully supported.

## Interface
- HPROT_VAL, 4'b0011, constant value driven on HPROT (data access, privileged).
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- dm_addr_i  in  32  byte address from the CPU.
- dm_data_s_i  in  32  store data, already lane-aligned (byte n on bits 8n+7:8n).
- dm_data_select_i  in  4  byte-lane enables.
- dm_store_i  in  1  store request; sampled only while dm_ready_o=1.
- dm_load_i  in  1  load request; sampled only while dm_ready_o=1.
- dm_ready_o  out  1  bridge idle and able to accept a request.
- dm_load_done_o  out  1  one-cycle pulse: dm_data_l_o is valid.
- dm_store_done_o  out  1  one-cycle pulse: the store has completed on AHB.
- dm_data_l_o  out  32  load data (full word from HRDATA), held until the next load completes.
- dm_err_o  out  1  one-cycle pulse, coincident with a done pulse: ERROR response or illegal select.
- HADDR  out  32, HTRANS  out  2, HWRITE  out  1, HSIZE  out  3, HBURST  out  3, HMASTLOCK  out  1, HPROT  out  4, HWDATA  out  32: AHB-Lite master outputs.
- HRDATA  in  32, HREADY  in  1, HRESP  in  1: AHB-Lite master inputs.

## Operation
- FSM states:
  - IDLE: dm_ready_o=1.
  - ADDR: drives HTRANS=NONSEQ (2'b10).
  - DATA: drives HTRANS=IDLE.
  - Transitions: IDLE→ADDR on a request; ADDR→DATA when HREADY=1; DATA→IDLE when HREADY=1.
- Request capture in IDLE:
  - dm_addr_i, dm_data_s_i, dm_data_select_i and the direction are latched.
  - If dm_store_i and dm_load_i are both high, the store wins.
- HSIZE and HADDR are derived from the select pattern:
  - 1111: HSIZE=2 (word); HADDR={addr[31:2],2'b00}.
  - 0011 or 1100: HSIZE=1 (halfword); HADDR={addr[31:2],sel[2],1'b0}.
  - One-hot: HSIZE=0 (byte); HADDR={addr[31:2],lane index}.
- Illegal select (any other pattern, including 0000):
  - No AHB transfer is issued; the FSM stays in IDLE.
  - On the next cycle the matching done pulse fires together with dm_err_o.
  - dm_data_l_o is unchanged.
- Constant outputs: HBURST=3'b000, HMASTLOCK=0, HPROT=HPROT_VAL.
- In the ADDR state, HADDR/HWRITE/HSIZE hold stable until HREADY=1.
- In the DATA state (stores), HWDATA carries the latched store data. HWDATA holds that value until the next store is latched.
- Load completion:
  - At the DATA-phase cycle with HREADY=1, HRDATA is registered into dm_data_l_o.
  - dm_load_done_o pulses in the following cycle.
- Store completion: dm_store_done_o pulses in the cycle after the DATA phase ends with HREADY=1.
- Error response:
  - HRESP=1 on the completing HREADY=1 cycle raises dm_err_o together with the done pulse.
  - For a load with an error, dm_data_l_o is loaded with 0.
  - The first ERROR cycle (HREADY=0, HRESP=1) is treated as a wait state.
- Reset values (rst_i=1, asynchronous, from any state):
  - FSM to IDLE; HTRANS=IDLE; HADDR=0; HWDATA=0; HWRITE=0; HSIZE=0.
  - dm_data_l_o=0; all done and error pulses 0; dm_ready_o=1.
  - Reset mid-transfer abandons the transfer with no done pulse.

## Timing
- Zero-wait load or store:
  - Request sampled at edge 0.
  - ADDR phase in cycle 1.
  - DATA phase in cycle 2.
  - Done pulse and dm_ready_o=1 in cycle 3.
- Each ADDR or DATA wait state (HREADY=0) adds exactly one cycle.
- dm_ready_o is low from the cycle after acceptance until the done cycle.
  - dm_ready_o is high in the done cycle, so a new request can be accepted there.
  - Back-to-back throughput: 3 cycles per transfer.
- Done and error pulses are exactly one cycle wide and are never asserted while dm_ready_o=0.
- Illegal select: done plus error one cycle after the request; dm_ready_o stays high throughout.

## Test plan
- Word store 0xDEADBEEF to 0x100 (sel 1111), then word load from 0x100, zero-wait slave:
  - Store: HADDR=0x100, HSIZE=2, HWRITE=1, HWDATA=0xDEADBEEF; store_done in cycle 3.
  - Load: dm_data_l_o=0xDEADBEEF with load_done 3 cycles after the request.
- Byte store sel 0100, addr 0x203, data 0x00AB0000: HADDR=0x202, HSIZE=0, HWDATA=0x00AB0000. Halfword sel 1100 at 0x200: HADDR=0x202, HSIZE=1.
- Slave inserts 2 ADDR-phase waits and 3 DATA-phase waits on a load:
  - Address/control held stable throughout; load_done at cycle 8.
  - dm_ready_o low in cycles 1–7.
- Two-cycle ERROR response on a store:
  - dm_store_done_o and dm_err_o pulse together.
  - A following load returns data normally with no error.
- Illegal select 0101 on a load:
  - HTRANS stays IDLE throughout.
  - load_done and dm_err_o pulse in cycle 1.
  - dm_data_l_o keeps its previous value.
- rst_i pulsed high during a DATA-phase wait:
  - HTRANS=IDLE and dm_ready_o=1 immediately; no done pulse.
  - The next request after reset completes normally.
